// File: rtl/vec_defs.sv
// vec_defs: shared widths, sweep depth and checker state encoding for the vector memories
package vec_defs;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COMPARE = 2'd2,
        FINISH  = 2'd3
    } state_e;
endpackage

// File: rtl/vec_sum_cmp.sv
// vec_sum_cmp: flags an entry whose C differs from the carry-extended sum A+B
// Ports: a_i, b_i (DATA_W) operands; c_i (DATA_W+1) stored result; mismatch_o high when c_i != a_i+b_i
module vec_sum_cmp #(
    parameter int DATA_W = vec_defs::DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W:0]   c_i,
    output logic              mismatch_o
);
    // Zero-extend before adding so the carry out (F+F=1E) is part of the compare.
    assign mismatch_o = c_i != ({1'b0, a_i} + {1'b0, b_i});
endmodule

// File: rtl/vector_sum_checker.sv
// vector_sum_checker: sweeps A/B/C memories on start and reports whether C == A + B everywhere
// Ports: clk, rst (sync active-high); start pulse; grant/req handshake for the shared address bus;
//        mem_addr to the memories; a_in/b_in/c_in registered read data; busy, done pulse,
//        pass, err_count, first_err_addr/first_err_valid results held until the next sweep
module vector_sum_checker
    import vec_defs::*;
#(
    parameter int ADDR_W = vec_defs::ADDR_W,
    parameter int DEPTH  = vec_defs::DEPTH,
    parameter int DATA_W = vec_defs::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W:0]   c_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_valid
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE  = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   first_q, first_d;
    logic [ADDR_W:0]     err_q, err_d;
    logic                fvalid_q, fvalid_d;
    logic                pass_q, pass_d;
    logic                mismatch;

    vec_sum_cmp #(.DATA_W(DATA_W)) u_cmp (
        .a_i       (a_in),
        .b_i       (b_in),
        .c_i       (c_in),
        .mismatch_o(mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            first_q  <= '0;
            err_q    <= '0;
            fvalid_q <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            first_q  <= first_d;
            err_q    <= err_d;
            fvalid_q <= fvalid_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        first_d  = first_q;
        err_d    = err_q;
        fvalid_d = fvalid_q;
        pass_d   = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ISSUE;
                    idx_d    = '0;
                    err_d    = '0;
                    fvalid_d = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            ISSUE: state_d = grant ? COMPARE : ISSUE;
            // Read data here belongs to the address issued under grant last cycle,
            // so grant is irrelevant in this state.
            COMPARE: begin
                if (mismatch) begin
                    err_d = err_q + ONE;
                    if (!fvalid_q) begin
                        first_d  = idx_q;
                        fvalid_d = 1'b1;
                    end
                end
                if (idx_q == LAST) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            FINISH: begin
                pass_d  = err_q == '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req             = state_q == ISSUE || state_q == COMPARE;
    assign busy            = state_q != IDLE;
    assign done            = state_q == FINISH;
    assign mem_addr        = idx_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_addr  = first_q;
    assign first_err_valid = fvalid_q;
endmodule

// File: tb/tb_vector_sum_checker.sv
// tb_vector_sum_checker: directed sweeps against a registered-read memory model with hand-chosen corruptions
module tb_vector_sum_checker;
    logic        clk = 1'b0;
    logic        rst, start, grant;
    logic        req, busy, done, pass, fev;
    logic [9:0]  mem_addr, fea, ra;
    logic [10:0] err;
    logic [3:0]  a_in, b_in;
    logic [4:0]  c_in;
    logic [3:0]  A[1024];
    logic [3:0]  B[1024];
    logic [4:0]  C[1024];
    int vectors = 0;
    int miscompares = 0;
    int done_cyc, ndone, stall_hold;

    always #5 clk = ~clk;

    vector_sum_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .grant          (grant),
        .req            (req),
        .mem_addr       (mem_addr),
        .a_in           (a_in),
        .b_in           (b_in),
        .c_in           (c_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err),
        .first_err_addr (fea),
        .first_err_valid(fev)
    );

    // Without the bus the memories see some other user's address.
    assign ra = (req && grant) ? mem_addr : ~mem_addr;

    always @(posedge clk) begin
        a_in <= A[ra];
        b_in <= B[ra];
        c_in <= C[ra];
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic load_clean();
        for (int i = 0; i < 1024; i++) begin
            A[i] = 4'((i * 7 + 3) ^ (i >> 5));
            B[i] = 4'd0;
            C[i] = {1'b0, A[i]};
        end
    endtask

    task automatic sweep(input int stall, input int restart, input int rst_at);
        done_cyc = -1;
        ndone = 0;
        stall_hold = 0;
        @(negedge clk);
        start = 1'b1;
        grant = 1'b1;
        for (int cyc = 1; cyc <= 2200; cyc++) begin
            @(negedge clk);
            start = (cyc == restart);
            rst   = (cyc == rst_at);
            grant = !(cyc >= stall && cyc < stall + 10);
            if (cyc >= stall && cyc < stall + 10 && req && mem_addr == 10'd300) stall_hold++;
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == rst_at + 1) begin
                check("rst_req", req, 0);
                check("rst_busy", busy, 0);
                check("rst_err", err, 0);
                check("rst_fea", fea, 0);
                check("rst_fev", fev, 0);
                check("rst_addr", mem_addr, 0);
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        grant = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        grant = 1'b1;
        load_clean();
        repeat (2) @(negedge clk);
        check("reset_req", req, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_fev", fev, 0);
        check("reset_err", err, 0);
        check("reset_fea", fea, 0);
        check("reset_addr", mem_addr, 0);
        rst = 1'b0;

        sweep(-100, -100, -100);
        check("clean_done_cyc", done_cyc, 2049);
        check("clean_ndone", ndone, 1);
        check("clean_pass", pass, 1);
        check("clean_err", err, 0);
        check("clean_fev", fev, 0);
        check("clean_busy", busy, 0);

        C[5]   = C[5] + 5'd1;
        C[700] = C[700] ^ 5'h10;
        sweep(-100, -100, -100);
        check("corrupt_done_cyc", done_cyc, 2049);
        check("corrupt_err", err, 2);
        check("corrupt_fea", fea, 5);
        check("corrupt_fev", fev, 1);
        check("corrupt_pass", pass, 0);

        load_clean();
        A[10] = 4'hF; B[10] = 4'hF; C[10] = 5'h1E;
        A[11] = 4'hF; B[11] = 4'hF; C[11] = 5'h0E;
        B[20] = 4'h3; C[20] = {1'b0, A[20]} + 5'd3;
        sweep(-100, -100, -100);
        check("carry_err", err, 1);
        check("carry_fea", fea, 11);
        check("carry_pass", pass, 0);

        load_clean();
        C[5]   = C[5] + 5'd1;
        C[700] = C[700] ^ 5'h10;
        sweep(601, -100, -100);
        check("stall_done_cyc", done_cyc, 2059);
        check("stall_hold300", stall_hold, 10);
        check("stall_ndone", ndone, 1);
        check("stall_err", err, 2);
        check("stall_fea", fea, 5);
        check("stall_pass", pass, 0);

        sweep(-100, 500, -100);
        check("restart_done_cyc", done_cyc, 2049);
        check("restart_ndone", ndone, 1);
        check("restart_err", err, 2);

        sweep(-100, -100, 1000);
        check("rst_ndone", ndone, 0);
        check("rst_idle", busy, 0);

        load_clean();
        sweep(-100, -100, -100);
        check("after_rst_done_cyc", done_cyc, 2049);
        check("after_rst_pass", pass, 1);
        check("after_rst_err", err, 0);

        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 0);
        @(negedge clk);
        check("rst_start_still_idle", busy, 0);
        check("rst_start_pass", pass, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vector_sum_checker.md
# vector_sum_checker

Read-side companion to the vector memories. On a start pulse it sweeps every address of ROM A, RAM B and RAM C, checks `C == A + B` (5-bit) at each entry, and reports pass/fail, the mismatch count and the first failing address. It sits beside the write/increment/init sequencers in `top`. It borrows the shared memory address bus only while `top` grants it, so it can verify the results of any earlier write, increment or init sweep.

## Interface
- `ADDR_W`, 10, memory address width
- `DEPTH`, 1024, number of entries swept (addresses 0..DEPTH-1)
- `DATA_W`, 4, A/B element width; C is DATA_W+1
- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  single-cycle request to begin a sweep
- `grant`  in  1  top releases the address bus this cycle (init_done and write/inc sequencers idle)
- `req`  out  1  checker wants the bus
- `mem_addr`  out  ADDR_W  address to muxed memory port
- `a_in`  in  DATA_W  ROM A registered read data
- `b_in`  in  DATA_W  RAM B registered read data
- `c_in`  in  DATA_W+1  RAM C registered read data
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at sweep end
- `pass`  out  1  last sweep had zero mismatches
- `err_count`  out  ADDR_W+1  mismatches in last sweep (0..DEPTH)
- `first_err_addr`  out  ADDR_W  address of first mismatch
- `first_err_valid`  out  1  first_err_addr is meaningful

## Operation
- States: IDLE, ISSUE, COMPARE, FINISH.
- IDLE: when `start`=1, go to ISSUE. Clear `err_count`, `first_err_valid`, `pass` and the scan index.
- ISSUE: drive `mem_addr`=index.
  - `grant`=1: go to COMPARE.
  - `grant`=0: stay in ISSUE. This stall can last any number of cycles.
- COMPARE: hold `mem_addr`. Memory data is for the address issued in the previous cycle. That address was owned while `grant`=1, so the data is valid whatever `grant` is now.
  - Mismatch test: `c_in != {1'b0,a_in} + {1'b0,b_in}`.
  - On mismatch: increment `err_count`. If `first_err_valid`=0, latch the index into `first_err_addr` and set `first_err_valid`.
  - If index == DEPTH-1, go to FINISH. Otherwise increment the index and go to ISSUE.
- FINISH: `done`=1 for this cycle only. `pass` <= (`err_count`==0, including the final compare). Go to IDLE.
- `req` = ISSUE or COMPARE. `busy` = any state except IDLE.
- `start` while busy is ignored; no restart and no queueing.
- Results hold from FINISH until the next accepted `start` or `rst`.
- The checker never writes memory. Top's address mux gives the checker `mem_addr` only when `req` and `grant` are both 1.
- Width rule: the sum is zero-extended to DATA_W+1, so the F+F=1E carry is checked exactly. `err_count` cannot overflow because its maximum is DEPTH.

## Timing
- Reset values: state IDLE; `req`, `busy`, `done`, `pass`, `first_err_valid` = 0; `err_count`, `first_err_addr`, `mem_addr` = 0.
- `rst` mid-sweep: return to IDLE next edge, results cleared, `req` drops the same edge. No partial `done`.
- Memory read latency is exactly 1 cycle (registered qspo).
- With `grant` held high and `start` in cycle 0:
  - ISSUE addr0 in cycle 1, COMPARE addr0 in cycle 2.
  - COMPARE addr DEPTH-1 in cycle 2·DEPTH.
  - `done` in cycle 2·DEPTH+1 (2049 for default).
- Each cycle with `grant`=0 in ISSUE adds exactly one cycle to the sweep.
- `start` and `rst` in the same cycle: `rst` wins.

## Structure
- Shared package/include `vec_defs`: ADDR_W, DEPTH, DATA_W, and the state encoding constants (IDLE=0, ISSUE=1, COMPARE=2, FINISH=3).
- One natural sub-module: `vec_sum_cmp`, a combinational DATA_W-bit add with carry and a compare against C, outputting `mismatch`. Everything else lives in one FSM module.

## Test plan
- Memory model holds A=ROM image, B=0, C=A. Set `grant`=1 and pulse `start` → `done` at cycle 2049, `pass`=1, `err_count`=0, `first_err_valid`=0.
- Corrupt C[5] and C[700] → `err_count`=2, `first_err_addr`=5, `pass`=0.
- Carry boundary: A=F, B=F. C=1E → no error; C=0E → error at that address.
- Drop `grant` for 10 cycles while in ISSUE at addr 300 → `mem_addr` holds 300, `done` at cycle 2059, results identical to the unstalled run.
- Pulse `start` again at cycle 500 of a sweep → ignored, `done` still at 2049, single `done` pulse.
- Assert `rst` at cycle 1000 → next cycle IDLE, all outputs at reset values, no `done`. A new `start` completes a normal sweep.
